// File: rtl/bubsys_snd_pkg.sv
// bubsys_snd_pkg
// Shared definitions for the sound mixer: controller state encoding and the
// fixed-point constants that define the per-channel gain arithmetic.
//   snd_state_t   : IDLE / MAC / SAT controller states
//   GAIN_BIAS     : added to the signed volume code (gain in 1/16 units)
//   GAIN_SHIFT    : right shift that removes the 1/16 gain scaling
//   ACC_HEADROOM  : extra accumulator bits above the input sample width
package bubsys_snd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_SAT  = 2'd2
    } snd_state_t;

    localparam int GAIN_BIAS    = 16;
    localparam int GAIN_SHIFT   = 4;
    localparam int ACC_HEADROOM = 6;

endpackage

// File: rtl/bubsys_snd_sat.sv
// bubsys_snd_sat
// Combinational signed clamp from an IN_W-bit accumulator to an OUT_W-bit
// sample, with a flag raised whenever the value had to be clamped.
//   acc  : signed accumulator value (IN_W bits)
//   sat  : clamped signed sample (OUT_W bits)
//   clip : high when acc lay outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module bubsys_snd_sat #(
    parameter int IN_W  = 22,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic        [OUT_W-1:0] sat,
    output logic                    clip
);
    import bubsys_snd_pkg::*;

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    // ~(2^k - 1) == -2^k in two's complement
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        sat  = acc[OUT_W-1:0];
        clip = 1'b0;
        if (acc > MAX_V) begin
            sat  = MAX_V[OUT_W-1:0];
            clip = 1'b1;
        end else if (acc < MIN_V) begin
            sat  = MIN_V[OUT_W-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/bubsys_snd_mixer.sv
// bubsys_snd_mixer
// Sequential multi-channel stereo mixer. A strobe in IDLE captures all
// channel samples, volume codes and routes; one channel per cycle is then
// scaled by a single shared multiplier and accumulated into L/R sums, which
// are clamped and registered to the outputs in the SAT cycle.
//   i_EMU_CLK72M  : clock
//   i_EMU_INITRST : asynchronous active-high reset
//   i_SAMPLE_STB  : one-cycle request for a new mix
//   i_CH_DATA     : NCH signed IW-bit samples, channel k at [k*IW +: IW]
//   i_VOL         : NCH 4-bit signed volume codes (-8..+7, gain 16+code /16)
//   i_ROUTE       : NCH 2-bit masks, bit0 = L, bit1 = R
//   o_SND_L/R     : signed OW-bit output samples, held between updates
//   o_VALID       : one-cycle pulse when o_SND_L/R update
//   o_BUSY        : high while a mix is in progress
//   o_DROP        : one-cycle pulse when a strobe arrives while busy
//   o_CLIP        : sticky clamp flags, bit0 = L, bit1 = R
module bubsys_snd_mixer #(
    parameter int NCH = 4,
    parameter int IW  = 16,
    parameter int OW  = 16
) (
    input  logic              i_EMU_CLK72M,
    input  logic              i_EMU_INITRST,
    input  logic              i_SAMPLE_STB,
    input  logic [NCH*IW-1:0] i_CH_DATA,
    input  logic [NCH*4-1:0]  i_VOL,
    input  logic [NCH*2-1:0]  i_ROUTE,
    output logic [OW-1:0]     o_SND_L,
    output logic [OW-1:0]     o_SND_R,
    output logic              o_VALID,
    output logic              o_BUSY,
    output logic              o_DROP,
    output logic [1:0]        o_CLIP
);
    import bubsys_snd_pkg::*;

    localparam int AW   = IW + ACC_HEADROOM;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    snd_state_t state_q, state_d;

    logic [NCH*IW-1:0] ch_data_q;
    logic [NCH*4-1:0]  vol_q;
    logic [NCH*2-1:0]  route_q;
    logic [IDXW-1:0]   idx_q;
    logic signed [AW-1:0] acc_l_q, acc_r_q;

    logic [IW-1:0] sample_sel;
    logic [3:0]    vol_sel;
    logic [1:0]    route_sel;
    logic          last_ch;
    logic          accept;

    logic signed [AW-1:0] sample_ext, vol_ext, gain_ext, product, term;

    logic [OW-1:0] sat_l, sat_r;
    logic          clip_l, clip_r;

    // Channel select for the shared multiplier, indexed by the MAC counter
    always_comb begin
        sample_sel = '0;
        vol_sel    = '0;
        route_sel  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (idx_q == IDXW'(k)) begin
                sample_sel = ch_data_q[k*IW +: IW];
                vol_sel    = vol_q[k*4 +: 4];
                route_sel  = route_q[k*2 +: 2];
            end
        end
    end

    // Full-width scaling: |sample * gain| < 2^(IW-1) * 24, which fits in AW bits
    always_comb begin
        sample_ext = {{ACC_HEADROOM{sample_sel[IW-1]}}, sample_sel};
        vol_ext    = {{(AW-4){vol_sel[3]}}, vol_sel};
        gain_ext   = vol_ext + AW'(GAIN_BIAS);
        product    = sample_ext * gain_ext;
        term       = product >>> GAIN_SHIFT;
    end

    assign last_ch = (idx_q == IDXW'(NCH - 1));

    // State register
    always_ff @(posedge i_EMU_CLK72M or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_SAMPLE_STB) state_d = ST_MAC;
            ST_MAC:  if (last_ch)      state_d = ST_SAT;
            ST_SAT:                    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_BUSY = (state_q != ST_IDLE);
        accept = (state_q == ST_IDLE) && i_SAMPLE_STB;
    end

    // Datapath and registered outputs
    always_ff @(posedge i_EMU_CLK72M or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            ch_data_q <= '0;
            vol_q     <= '0;
            route_q   <= '0;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            o_SND_L   <= '0;
            o_SND_R   <= '0;
            o_VALID   <= 1'b0;
            o_DROP    <= 1'b0;
            o_CLIP    <= '0;
        end else begin
            o_VALID <= 1'b0;
            o_DROP  <= i_SAMPLE_STB && (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ch_data_q <= i_CH_DATA;
                        vol_q     <= i_VOL;
                        route_q   <= i_ROUTE;
                        idx_q     <= '0;
                        acc_l_q   <= '0;
                        acc_r_q   <= '0;
                    end
                end
                ST_MAC: begin
                    if (route_sel[0]) acc_l_q <= acc_l_q + term;
                    if (route_sel[1]) acc_r_q <= acc_r_q + term;
                    idx_q <= idx_q + 1'b1;
                end
                ST_SAT: begin
                    o_SND_L <= sat_l;
                    o_SND_R <= sat_r;
                    o_CLIP  <= o_CLIP | {clip_r, clip_l};
                    o_VALID <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    bubsys_snd_sat #(.IN_W(AW), .OUT_W(OW)) u_sat_l (
        .acc  (acc_l_q),
        .sat  (sat_l),
        .clip (clip_l)
    );

    bubsys_snd_sat #(.IN_W(AW), .OUT_W(OW)) u_sat_r (
        .acc  (acc_r_q),
        .sat  (sat_r),
        .clip (clip_r)
    );

endmodule

// File: tb/tb_bubsys_snd_mixer.sv
module tb_bubsys_snd_mixer;
    localparam int NCH  = 4;
    localparam int IW   = 16;
    localparam int OW   = 16;
    localparam int MAXO = 32767;
    localparam int MINO = -32768;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stb = 1'b0;
    logic [NCH*IW-1:0] ch_data = '0;
    logic [NCH*4-1:0]  vol_bus = '0;
    logic [NCH*2-1:0]  route_bus = '0;
    logic [OW-1:0]     snd_l, snd_r;
    logic              valid, busy, drop;
    logic [1:0]        clip;

    always #5 clk = ~clk;

    bubsys_snd_mixer #(.NCH(NCH), .IW(IW), .OW(OW)) dut (
        .i_EMU_CLK72M  (clk),
        .i_EMU_INITRST (rst),
        .i_SAMPLE_STB  (stb),
        .i_CH_DATA     (ch_data),
        .i_VOL         (vol_bus),
        .i_ROUTE       (route_bus),
        .o_SND_L       (snd_l),
        .o_SND_R       (snd_r),
        .o_VALID       (valid),
        .o_BUSY        (busy),
        .o_DROP        (drop),
        .o_CLIP        (clip)
    );

    int ncomp = 0;
    int nfail = 0;

    int samp  [NCH];
    int vol   [NCH];
    int route [NCH];
    int exp_l, exp_r;
    logic [1:0] exp_clip = 2'b00;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] expv);
        ncomp++;
        assert (got === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // floor(p / 16) for any sign
    function automatic int div16_floor(input int p);
        if (p >= 0) return p / 16;
        return -((-p + 15) / 16);
    endfunction

    // Reference: gain = 16 + signed code, term = floor(sample*gain/16), sum, clamp
    task automatic model_mix();
        int sl, sr, g, t;
        sl = 0;
        sr = 0;
        for (int k = 0; k < NCH; k++) begin
            g = (vol[k] >= 8) ? (16 + vol[k] - 16) : (16 + vol[k]);
            t = div16_floor(samp[k] * g);
            if (route[k] % 2 == 1) sl += t;
            if (route[k] >= 2)     sr += t;
        end
        exp_l = sl;
        exp_r = sr;
        if (sl > MAXO) begin exp_l = MAXO; exp_clip[0] = 1'b1; end
        if (sl < MINO) begin exp_l = MINO; exp_clip[0] = 1'b1; end
        if (sr > MAXO) begin exp_r = MAXO; exp_clip[1] = 1'b1; end
        if (sr < MINO) begin exp_r = MINO; exp_clip[1] = 1'b1; end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NCH; k++) begin
            ch_data[k*IW +: IW]  = IW'(samp[k]);
            vol_bus[k*4 +: 4]    = 4'(vol[k]);
            route_bus[k*2 +: 2]  = 2'(route[k]);
        end
    endtask

    task automatic scramble_inputs();
        ch_data   = {$urandom(), $urandom()};
        vol_bus   = 16'($urandom());
        route_bus = 8'($urandom());
    endtask

    task automatic rand_channels();
        for (int k = 0; k < NCH; k++) begin
            samp[k]  = int'($urandom_range(0, 65535)) - 32768;
            vol[k]   = int'($urandom_range(0, 15));
            route[k] = int'($urandom_range(0, 3));
        end
    endtask

    task automatic set_all(input int s, input int v, input int r);
        for (int k = 0; k < NCH; k++) begin
            samp[k] = s; vol[k] = v; route[k] = r;
        end
    endtask

    // One complete mix; inputs are garbled right after capture
    task automatic run_mix(input string tag);
        int cyc, drops;
        logic busy_ok, got_valid;
        model_mix();
        drive_inputs();
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        scramble_inputs();
        busy_ok   = busy;
        drops     = 0;
        cyc       = 0;
        got_valid = 1'b0;
        while (!got_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            drops += int'(drop);
            if (valid) got_valid = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, cyc, NCH + 1);
        check({tag, "_L"}, $signed(snd_l), exp_l);
        check({tag, "_R"}, $signed(snd_r), exp_r);
        check({tag, "_clip"}, clip, exp_clip);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_nodrop"}, drops, 0);
        @(posedge clk); #1;
        check({tag, "_valid_pulse"}, valid, 0);
        check({tag, "_hold_L"}, $signed(snd_l), exp_l);
    endtask

    initial begin
        int ndrop, nval, vcyc, vl, vr;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_L", snd_l, 0);
        check("rst_R", snd_r, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        check("rst_clip", clip, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Unity gain
        set_all(0, 0, 3);
        samp[0] = 100; samp[1] = 200; samp[2] = -50; samp[3] = 0;
        run_mix("unity");
        check("unity_L_250", $signed(snd_l), 250);
        check("unity_R_250", $signed(snd_r), 250);

        // Gain codes on a single channel
        set_all(0, 0, 3); samp[0] = 1600; vol[0] = 7;
        run_mix("vol7");
        check("vol7_2300", $signed(snd_l), 2300);
        vol[0] = 8;
        run_mix("vol8");
        check("vol8_800", $signed(snd_l), 800);
        vol[0] = 15;
        run_mix("vol15");
        check("vol15_1500", $signed(snd_r), 1500);

        // Left-only route with positive clamp; flag must stick
        set_all(0, 0, 3); samp[0] = 32767; vol[0] = 7; route[0] = 1;
        run_mix("clipL");
        check("clipL_L_lit", $signed(snd_l), 32767);
        check("clipL_R_lit", $signed(snd_r), 0);
        check("clipL_flag_lit", clip, 2'b01);
        set_all(10, 0, 3);
        run_mix("sticky");
        check("sticky_flag_lit", clip, 2'b01);

        // Negative clamp on both sides
        set_all(-32768, 7, 3);
        run_mix("negclamp");
        check("neg_L_lit", $signed(snd_l), -32768);
        check("neg_R_lit", $signed(snd_r), -32768);
        check("neg_flag_lit", clip, 2'b11);

        // Zero route contributes nothing
        set_all(1000, 0, 3); samp[2] = 30000; vol[2] = 7; route[2] = 0;
        run_mix("route0");
        check("route0_L_lit", $signed(snd_l), 3000);

        // Second strobe two cycles into a mix is dropped
        rand_channels();
        model_mix();
        drive_inputs();
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        ndrop = int'(drop); nval = 0; vcyc = 0; vl = 0; vr = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                rand_channels();
                drive_inputs();
                stb = 1'b1;
            end else begin
                stb = 1'b0;
            end
            @(posedge clk); #1;
            ndrop += int'(drop);
            if (valid) begin
                nval++; vcyc = i + 1;
                vl = $signed(snd_l); vr = $signed(snd_r);
            end
        end
        check("busystb_drops", ndrop, 1);
        check("busystb_valids", nval, 1);
        check("busystb_latency", vcyc, NCH + 1);
        check("busystb_L", vl, exp_l);
        check("busystb_R", vr, exp_r);

        // Reset in the middle of a mix
        set_all(500, 3, 3);
        drive_inputs();
        stb = 1'b1;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_L", snd_l, 0);
        check("midrst_R", snd_r, 0);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop, 0);
        check("midrst_clip", clip, 0);
        exp_clip = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            nval += int'(valid);
        end
        check("midrst_no_valid", nval, 0);
        run_mix("post_rst");

        // Randomized mixes
        for (int n = 0; n < 25; n++) begin
            rand_channels();
            run_mix($sformatf("rand%0d", n));
        end

        // Outputs hold through idle cycles
        repeat (6) @(posedge clk);
        #1;
        check("idle_hold_L", $signed(snd_l), exp_l);
        check("idle_hold_R", $signed(snd_r), exp_r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/bubsys_snd_mixer.md
BUBSYS_SND_MIXER -- requirements
Module: bubsys_snd_mixer

Interface
REQ-001 SHALL have parameter NCH, default 4: number of input channels, 1..8.
REQ-002 SHALL have parameter IW, default 16: signed input sample width.
REQ-003 SHALL have parameter OW, default 16: signed output sample width, OW <= IW+4.
REQ-004 SHALL have port i_EMU_CLK72M, input, 1 bit: the single clock.
REQ-005 SHALL have port i_EMU_INITRST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port i_SAMPLE_STB, input, 1 bit: one-cycle pulse that requests a new mix.
REQ-007 SHALL have port i_CH_DATA, input, NCH*IW bits: signed samples; channel k is at [k*IW +: IW].
REQ-008 SHALL have port i_VOL, input, NCH*4 bits: per-channel volume code; 0..7 = +0..+7, 8..15 = -8..-1.
REQ-009 SHALL have port i_ROUTE, input, NCH*2 bits: per channel, bit0 enables L and bit1 enables R.
REQ-010 SHALL have port o_SND_L, output, OW bits: signed left output sample.
REQ-011 SHALL have port o_SND_R, output, OW bits: signed right output sample.
REQ-012 SHALL have port o_VALID, output, 1 bit: one-cycle pulse when o_SND_L and o_SND_R update.
REQ-013 SHALL have port o_BUSY, output, 1 bit: high while a mix is in progress.
REQ-014 SHALL have port o_DROP, output, 1 bit: one-cycle pulse when a strobe is rejected.
REQ-015 SHALL have port o_CLIP, output, 2 bits: sticky saturation flags, bit0 = L, bit1 = R; cleared only by reset.

Function
REQ-016 SHALL implement the states IDLE, MAC and SAT.
REQ-017 In IDLE, i_SAMPLE_STB SHALL capture i_CH_DATA, i_VOL and i_ROUTE into registers, clear both accumulators, set the channel index to 0 and enter MAC.
REQ-018 In MAC, SHALL process one channel per cycle, in index order 0..NCH-1.
REQ-019 Per-channel gain SHALL be (16 + sign-extended vol), giving 8..23 in 1/16 units; vol=0 is unity gain.
REQ-020 Per-channel term SHALL be (sample * gain) arithmetic-shifted right by 4, computed at full width with no intermediate truncation.
REQ-021 Each term SHALL be added to the L accumulator only if route bit0 is set, and to the R accumulator only if route bit1 is set.
REQ-022 Accumulators SHALL be IW+6 bits signed, which makes internal overflow impossible.
REQ-023 After channel NCH-1, SHALL enter SAT.
REQ-024 In SAT, SHALL clamp each accumulator to [-2^(OW-1), 2^(OW-1)-1] and register the result to the outputs.
REQ-025 In SAT, SHALL set o_CLIP bit0 if the L value was clamped and o_CLIP bit1 if the R value was clamped.
REQ-026 In SAT, SHALL pulse o_VALID and return to IDLE.
REQ-027 Latency from the strobe cycle to o_VALID SHALL be exactly NCH+1 cycles (NCH MAC cycles + 1 SAT cycle).
REQ-028 o_BUSY SHALL be high in MAC and SAT, and low in IDLE.
REQ-029 A strobe arriving in MAC or SAT SHALL be ignored, pulse o_DROP, and leave the mix in progress unaffected.
REQ-030 Input changes after capture SHALL NOT affect the mix in progress.
REQ-031 o_SND_L and o_SND_R SHALL hold their last value between o_VALID pulses.
REQ-032 A channel with a route mask of 0 SHALL contribute nothing to either output.

Reset
REQ-033 Asserting i_EMU_INITRST SHALL immediately force state IDLE.
REQ-034 Asserting i_EMU_INITRST SHALL immediately force o_SND_L=0, o_SND_R=0, o_VALID=0, o_BUSY=0, o_DROP=0 and o_CLIP=0.
REQ-035 Asserting i_EMU_INITRST SHALL immediately clear the accumulators and the channel index.
REQ-036 Reset asserted mid-mix SHALL abort the mix with no o_VALID pulse.
REQ-037 The first strobe after reset deassertion SHALL be accepted normally.

Structure
REQ-038 A shared package bubsys_snd_pkg SHALL hold the state enum, the gain bias constant (16), the shift constant (4) and the accumulator headroom constant (6).
REQ-039 A sub-module bubsys_snd_sat (combinational signed clamp with a clip flag) SHALL be instantiated once per output side.
REQ-040 The multiplier SHALL be a single shared instance used sequentially across channels, not one per channel.

Verification
REQ-041 Unity gain: NCH=4, all vol=0, route=3, samples 100, 200, -50, 0 -> o_SND_L = o_SND_R = 250, with o_VALID exactly 5 cycles after the strobe.
REQ-042 Gain codes: single channel sample 1600 -> vol=7 gives 2300; vol=8 gives 800; vol=15 gives 1500.
REQ-043 Routing and saturation: ch0=32767 at vol=7 with route=1, others 0 -> o_SND_L = 32767, o_SND_R = 0, o_CLIP = 2'b01, and o_CLIP stays set after a later unclipped mix.
REQ-044 Negative clamp: all four channels -32768, vol=7, route=3 -> both outputs = -32768 and o_CLIP = 2'b11.
REQ-045 Busy strobe: a second strobe 2 cycles after the first -> o_DROP pulses once, exactly one o_VALID occurs, and the result matches the first capture.
REQ-046 Reset mid-mix: assert i_EMU_INITRST at MAC cycle 2 -> all outputs are 0 the same cycle, no o_VALID follows, and the next strobe completes normally.
